alu_op_issuer: RTL and testbench

//  Command-side counterpart of the ALU control decoder. It accepts operation

---
 rtl/alu_op_issuer_pkg.sv | 28 ++
 rtl/alu_req_fifo.sv | 64 ++++++
 rtl/alu_op_issuer.sv | 152 +++++++++++++++
 tb/tb_alu_op_issuer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_issuer_pkg.sv
// Shared opcode and FSM encodings for the ALU request issuer and its request FIFO.
package alu_op_issuer_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpXor  = 3'd2,
        OpSlt  = 3'd3,
        OpAnd  = 3'd4,
        OpNand = 3'd5,
        OpNor  = 3'd6,
        OpOr   = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } issue_state_e;

    localparam int unsigned OpW = 3;

    // FIFO payload is {op, a, b}.
    function automatic int unsigned payload_width(int unsigned width);
        return OpW + 2 * width;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO holding {op, a, b}; push is ignored when full, pop when empty.
module alu_req_fifo
    import alu_op_issuer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push_i,
    input  logic [payload_width(WIDTH)-1:0]   push_data_i,
    input  logic                              pop_i,
    output logic [payload_width(WIDTH)-1:0]   pop_data_o,
    output logic                              full_o,
    output logic                              empty_o
);

    localparam int unsigned PW   = payload_width(WIDTH);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

    logic [PW-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            push_en, pop_en;

    assign full_o     = (count_q == DepthCnt);
    assign empty_o    = (count_q == '0);
    assign push_en    = push_i && !full_o;
    assign pop_en     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Queues ALU op requests, issues them with held operands, waits ALU_LAT cycles, returns result.
// Macro ALU_ISSUER_FLAGS_EN adds the rsp_flags port and the flag capture registers.
module alu_op_issuer
    import alu_op_issuer_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [2:0]       alu_command,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result
`ifdef ALU_ISSUER_FLAGS_EN
    ,
    output logic [2:0]       rsp_flags
`endif
);

    localparam int unsigned PW   = payload_width(WIDTH);
    localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ALU_LAT - 1);

    logic [PW-1:0]    head_data;
    logic             fifo_full, fifo_empty, fifo_pop;

    issue_state_e     state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    alu_op_e          cmd_q, cmd_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
`ifdef ALU_ISSUER_FLAGS_EN
    logic [2:0]       flags_q, flags_d;
`else
    logic             unused_flags;
    assign unused_flags = ^{alu_carryout, alu_zero, alu_overflow};
`endif

    assign req_ready = !fifo_full;

    alu_req_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (req_valid),
        .push_data_i ({req_op, req_a, req_b}),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        fifo_pop     = 1'b0;
`ifdef ALU_ISSUER_FLAGS_EN
        flags_d      = flags_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) fifo_pop = 1'b1;
            end
            StIssue: begin
                if (cnt_q == CntLast) begin
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_result;
`ifdef ALU_ISSUER_FLAGS_EN
                    flags_d      = {alu_carryout, alu_zero, alu_overflow};
`endif
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                    if (!fifo_empty) fifo_pop = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // A pop from either IDLE or RESP loads the ALU operands and restarts the latency count.
        if (fifo_pop) begin
            cmd_d   = alu_op_e'(head_data[PW-1 -: OpW]);
            a_d     = head_data[2*WIDTH-1 -: WIDTH];
            b_d     = head_data[WIDTH-1:0];
            cnt_d   = '0;
            state_d = StIssue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            cmd_q        <= OpAdd;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
`ifdef ALU_ISSUER_FLAGS_EN
            flags_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
`ifdef ALU_ISSUER_FLAGS_EN
            flags_q      <= flags_d;
`endif
        end
    end

    assign alu_command = cmd_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
`ifdef ALU_ISSUER_FLAGS_EN
    assign rsp_flags   = flags_q;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: behavioural ALU, expected-response queue, directed steps.
module tb_alu_op_issuer;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ALU_LAT = 1;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       alu_command;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carryout;
    logic             alu_zero;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
`ifdef ALU_ISSUER_FLAGS_EN
    logic [2:0]       rsp_flags;
`endif

    int          n_checks;
    int          n_fail;
    int          cycle;
    int          n_rsp;
    int          last_hs;
    bit          chk_period;
    logic [34:0] exp_q[$];
    logic [31:0] saved_a[5];

    // {carry, zero, overflow, result} straight from the arithmetic meaning of each opcode.
    function automatic logic [34:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a ^ b;
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {c, (r == 32'd0), v, r};
    endfunction

    // With ALU_LAT=1 the result must be settled one cycle after the registered alu_* change.
    assign {alu_carryout, alu_zero, alu_overflow, alu_result} = ref_alu(alu_command, alu_a, alu_b);

    alu_op_issuer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ALU_LAT (ALU_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_command  (alu_command),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result)
`ifdef ALU_ISSUER_FLAGS_EN
        ,
        .rsp_flags    (rsp_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are sampled at the falling edge, i.e. the values the next rising edge will see.
    task automatic tick();
        logic [34:0] e;
        @(negedge clk);
        if (rst_n) begin
            if (req_valid && req_ready) exp_q.push_back(ref_alu(req_op, req_a, req_b));
            if (rsp_valid && rsp_ready) begin
                if (chk_period && last_hs >= 0)
                    chk("rsp_period", 64'(cycle - last_hs), 64'(ALU_LAT + 1));
                last_hs = cycle;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_result", 64'(rsp_result), 64'(e[31:0]));
`ifdef ALU_ISSUER_FLAGS_EN
                    chk("rsp_flags", 64'(rsp_flags), 64'(e[34:32]));
`endif
                    n_rsp++;
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int budget);
        bit acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        for (int i = 0; i < budget && !acc; i++) begin
            acc = req_ready;
            tick();
        end
        req_valid = 1'b0;
        chk("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_rsp(input int budget);
        for (int i = 0; i < budget && !rsp_valid; i++) tick();
        chk("rsp_wait", 64'(rsp_valid), 64'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n0;
        logic [2:0] op;
        n_checks   = 0;
        n_fail     = 0;
        cycle      = 0;
        n_rsp      = 0;
        last_hs    = -1;
        chk_period = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b0;

        // Reset state
        #3;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_alu_command", 64'(alu_command), 64'd0);
        chk("reset_alu_a", 64'(alu_a), 64'd0);
        chk("reset_alu_b", 64'(alu_b), 64'd0);
        chk("reset_rsp_result", 64'(rsp_result), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // 1: ADD 5+3, exact latency
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd5;
        req_b     = 32'd3;
        tick();
        req_valid = 1'b0;
        tick();
        chk("t1_alu_command", 64'(alu_command), 64'd0);
        chk("t1_alu_a", 64'(alu_a), 64'd5);
        chk("t1_alu_b", 64'(alu_b), 64'd3);
        chk("t1_rsp_not_yet", 64'(rsp_valid), 64'd0);
        tick();
        chk("t1_rsp_valid_k2", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_result", 64'(rsp_result), 64'd8);
        tick();
        chk("t1_rsp_dropped", 64'(rsp_valid), 64'd0);
        chk("t1_alu_a_held", 64'(alu_a), 64'd5);

        // 2: SUB 3-5
        send(3'd1, 32'd3, 32'd5, 4);
        wait_rsp(10);
        chk("t2_result", 64'(rsp_result), 64'hFFFF_FFFE);
`ifdef ALU_ISSUER_FLAGS_EN
        chk("t2_flags", 64'(rsp_flags), 64'd0);
`endif
        tick();

        // 3: fill with rsp_ready low; DEPTH queued + 1 in flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_op    = 3'($urandom_range(0, 7));
            req_a     = $urandom;
            req_b     = $urandom;
            chk("t3_fill_ready", 64'(req_ready), (i < 5) ? 64'd1 : 64'd0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n0 = n_rsp;
        drain(40);
        chk("t3_rsp_count", 64'(n_rsp - n0), 64'd5);

        // 4: overflow and zero corner cases
        send(3'd1, 32'h8000_0000, 32'd1, 4);
        wait_rsp(10);
        chk("t4_ovf_result", 64'(rsp_result), 64'h7FFF_FFFF);
`ifdef ALU_ISSUER_FLAGS_EN
        chk("t4_ovf_flag", 64'(rsp_flags[0]), 64'd1);
`endif
        tick();
        send(3'd1, 32'd7, 32'd7, 4);
        wait_rsp(10);
        chk("t4_zero_result", 64'(rsp_result), 64'd0);
`ifdef ALU_ISSUER_FLAGS_EN
        chk("t4_zero_flag", 64'(rsp_flags[1]), 64'd1);
`endif
        tick();

        // 5: reset while an op is in ISSUE with three queued behind it
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            saved_a[i] = $urandom;
            send(3'($urandom_range(0, 7)), saved_a[i], $urandom, 4);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t5_issue_a", 64'(alu_a), 64'(saved_a[1]));
        chk("t5_issue_no_rsp", 64'(rsp_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_rst_req_ready", 64'(req_ready), 64'd1);
        chk("t5_rst_alu_command", 64'(alu_command), 64'd0);
        chk("t5_rst_alu_a", 64'(alu_a), 64'd0);
        chk("t5_rst_alu_b", 64'(alu_b), 64'd0);
        tick();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_no_late_rsp", 64'(rsp_valid), 64'd0);
        end

        // 6: back-to-back SLT/AND/OR, pointers wrap past DEPTH
        chk_period = 1'b1;
        last_hs    = -1;
        n0         = n_rsp;
        for (int i = 0; i < 9; i++) begin
            op = (i % 3 == 0) ? 3'd3 : ((i % 3 == 1) ? 3'd4 : 3'd7);
            send(op, $urandom, $urandom, 20);
        end
        drain(60);
        chk("t6_rsp_count", 64'(n_rsp - n0), 64'd9);
        chk_period = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
